// File: rtl/dmem_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
// Also holds the access-legality check used when a request is accepted.
package dmem_pkg;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    // Illegal = conflicting read/write, misaligned byte address, or word index past the array.
    function automatic logic access_illegal(
        input logic              rd,
        input logic              wr,
        input logic [WORD_W-1:0] addr,
        input int unsigned       depth_words
    );
        logic [WORD_W-1:0] word_idx;
        word_idx = {2'b00, addr[WORD_W-1:2]};
        return (rd & wr) | (addr[1:0] != 2'b00) | (word_idx >= depth_words);
    endfunction

endpackage

// File: rtl/wait_counter.sv
// Wait-state down-counter: loadable, decrements toward zero, flags zero.
// Saturates at zero so a stray decrement cannot wrap.
module wait_counter
    import dmem_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count_r;

    // Count register: load has priority over decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && (count_r != {CNT_W{1'b0}})) begin
            count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/data_memory_responder.sv
// Multi-cycle data memory for the MEM stage: one word load/store at a time,
// LATENCY stall cycles, then a one-cycle ready (and err on illegal access).
module data_memory_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 32,
    parameter int LATENCY     = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [WORD_W-1:0] addr_i,
    input  logic [WORD_W-1:0] data_i,
    output logic [WORD_W-1:0] data_o,
    output logic              stall_o,
    output logic              ready_o,
    output logic              err_o
);

    localparam int               IDX_W       = $clog2(DEPTH_WORDS);
    localparam logic             SINGLE_WAIT = (LATENCY == 1) ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] CNT_LOAD    = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : {CNT_W{1'b0}};

    state_e              state_r;
    logic                rd_r;
    logic                wr_r;
    logic [IDX_W-1:0]    idx_r;
    logic [WORD_W-1:0]   wdata_r;
    logic                illegal_r;
    logic [WORD_W-1:0]   mem_r [DEPTH_WORDS];

    logic                req_s;
    logic                illegal_s;
    logic                stall_s;
    logic                cnt_load_s;
    logic                cnt_dec_s;
    logic                cnt_zero_s;
    logic                done_entry_s;
    logic                acc_rd_s;
    logic                acc_wr_s;
    logic [IDX_W-1:0]    acc_idx_s;
    logic [WORD_W-1:0]   acc_data_s;
    logic                acc_illegal_s;

    wait_counter u_wait_counter (
        .clk      (clk_i),
        .rst_n    (rst_i),
        .load     (cnt_load_s),
        .load_val (CNT_LOAD),
        .dec      (cnt_dec_s),
        .zero     (cnt_zero_s)
    );

    // Next-step decode; with LATENCY=1 the DONE-entry edge comes straight from IDLE,
    // so the access fields are taken from the live inputs there and from the latch otherwise.
    always_comb begin
        req_s        = MemRead_i | MemWrite_i;
        illegal_s    = access_illegal(MemRead_i, MemWrite_i, addr_i, DEPTH_WORDS);
        stall_s      = 1'b0;
        cnt_load_s   = 1'b0;
        cnt_dec_s    = 1'b0;
        done_entry_s = 1'b0;
        case (state_r)
            IDLE: begin
                stall_s      = req_s;
                cnt_load_s   = req_s & ~SINGLE_WAIT;
                done_entry_s = req_s & SINGLE_WAIT;
            end
            WAIT: begin
                stall_s      = 1'b1;
                cnt_dec_s    = ~cnt_zero_s;
                done_entry_s = cnt_zero_s;
            end
            DONE: begin
                stall_s      = 1'b0;
            end
            default: begin
                stall_s      = 1'b0;
            end
        endcase
        done_entry_s = done_entry_s & rst_i;
        if (state_r == IDLE) begin
            acc_rd_s      = MemRead_i;
            acc_wr_s      = MemWrite_i;
            acc_idx_s     = addr_i[IDX_W+1:2];
            acc_data_s    = data_i;
            acc_illegal_s = illegal_s;
        end else begin
            acc_rd_s      = rd_r;
            acc_wr_s      = wr_r;
            acc_idx_s     = idx_r;
            acc_data_s    = wdata_r;
            acc_illegal_s = illegal_r;
        end
    end

    assign stall_o = stall_s & rst_i;

    // FSM, request latch and registered completion outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r   <= IDLE;
            rd_r      <= 1'b0;
            wr_r      <= 1'b0;
            idx_r     <= {IDX_W{1'b0}};
            wdata_r   <= {WORD_W{1'b0}};
            illegal_r <= 1'b0;
            data_o    <= {WORD_W{1'b0}};
            ready_o   <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            ready_o <= done_entry_s;
            err_o   <= done_entry_s & acc_illegal_s;
            if (done_entry_s && acc_illegal_s) begin
                data_o <= {WORD_W{1'b0}};
            end else if (done_entry_s && acc_rd_s) begin
                data_o <= mem_r[acc_idx_s];
            end else begin
                data_o <= data_o;
            end
            case (state_r)
                IDLE: begin
                    if (req_s) begin
                        rd_r      <= MemRead_i;
                        wr_r      <= MemWrite_i;
                        idx_r     <= addr_i[IDX_W+1:2];
                        wdata_r   <= data_i;
                        illegal_r <= illegal_s;
                        state_r   <= SINGLE_WAIT ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_zero_s) begin
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Backing array is deliberately unreset; only a legal store on the DONE-entry edge writes it.
    always_ff @(posedge clk_i) begin
        if (done_entry_s && acc_wr_s && !acc_illegal_s) begin
            mem_r[acc_idx_s] <= acc_data_s;
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: LATENCY=2 instance for protocol/error/reset
// cases, LATENCY=1 instance for the back-to-back load sweep.
module tb_data_memory_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic [31:0] data2, data1;
    logic        stall2, stall1, ready2, ready1, err2, err1;

    logic        sel;
    int          lat;
    int          cyc = 0;
    int          last_ready_cyc;
    int          prev_ready;
    int          checks = 0;
    int          failures = 0;

    wire [31:0] data_m  = sel ? data1  : data2;
    wire        stall_m = sel ? stall1 : stall2;
    wire        ready_m = sel ? ready1 : ready2;
    wire        err_m   = sel ? err1   : err2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_memory_responder #(.DEPTH_WORDS(32), .LATENCY(2)) dut (
        .clk_i(clk), .rst_i(rst_n), .MemRead_i(mem_read), .MemWrite_i(mem_write),
        .addr_i(addr), .data_i(wdata), .data_o(data2), .stall_o(stall2),
        .ready_o(ready2), .err_o(err2)
    );

    data_memory_responder #(.DEPTH_WORDS(32), .LATENCY(1)) dut1 (
        .clk_i(clk), .rst_i(rst_n), .MemRead_i(mem_read), .MemWrite_i(mem_write),
        .addr_i(addr), .data_i(wdata), .data_o(data1), .stall_o(stall1),
        .ready_o(ready1), .err_o(err1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        mem_read = 1'b0; mem_write = 1'b0; addr = 32'h0; wdata = 32'h0;
    endtask

    // Called #1 after a rising edge: presents a request, checks lat stall cycles, then DONE.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] d, input logic [31:0] exp_d, input logic exp_e);
        mem_read = rd; mem_write = wr; addr = a; wdata = d;
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            chk("stall_wait", {31'd0, stall_m}, 32'd1);
            chk("ready_wait", {31'd0, ready_m}, 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("stall_done", {31'd0, stall_m}, 32'd0);
        chk("ready_done", {31'd0, ready_m}, 32'd1);
        chk("err_done",   {31'd0, err_m},   {31'd0, exp_e});
        chk("data_done",  data_m, exp_d);
        last_ready_cyc = cyc;
        @(posedge clk); #1;
    endtask

    initial begin
        sel = 1'b0; lat = 2; last_ready_cyc = 0;
        rst_n = 1'b0;
        idle();
        mem_read = 1'b1; addr = 32'h0000_000C;
        dut.mem_r[1] = 32'h1111_1111;
        dut.mem_r[2] = 32'h2222_2222;
        dut.mem_r[3] = 32'hDEAD_BEEF;
        dut.mem_r[4] = 32'h4444_4444;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall_forced", {31'd0, stall2}, 32'd0);
        chk("rst_ready", {31'd0, ready2}, 32'd0);
        chk("rst_err",   {31'd0, err2},   32'd0);
        chk("rst_data",  data2, 32'd0);
        idle();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_stall", {31'd0, stall2}, 32'd0);
        chk("idle_ready", {31'd0, ready2}, 32'd0);
        @(posedge clk); #1;

        // Basic load, then store followed immediately by a load of the same word.
        do_access(1'b1, 1'b0, 32'h0000_000C, 32'h0, 32'hDEAD_BEEF, 1'b0);
        idle();
        @(posedge clk); #1;
        do_access(1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0);
        prev_ready = last_ready_cyc;
        do_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, 1'b0);
        chk("ready_spacing_l2", last_ready_cyc - prev_ready, 32'd3);
        chk("mem4_written", dut.mem_r[4], 32'h1234_5678);

        // Illegal accesses: misaligned, out of range, read+write together.
        do_access(1'b1, 1'b0, 32'h0000_000E, 32'h0, 32'h0, 1'b1);
        chk("mem3_after_misaligned", dut.mem_r[3], 32'hDEAD_BEEF);
        do_access(1'b1, 1'b0, 32'h0000_0080, 32'h0, 32'h0, 1'b1);
        do_access(1'b1, 1'b0, 32'h0000_000C, 32'h0, 32'hDEAD_BEEF, 1'b0);
        do_access(1'b1, 1'b1, 32'h0000_0004, 32'hFFFF_FFFF, 32'h0, 1'b1);
        chk("mem1_after_rw_both", dut.mem_r[1], 32'h1111_1111);
        idle();
        @(posedge clk); #1;

        // Store aborted by reset during WAIT, then re-run with the held request.
        do_access(1'b1, 1'b0, 32'h0000_000C, 32'h0, 32'hDEAD_BEEF, 1'b0);
        mem_read = 1'b0; mem_write = 1'b1; addr = 32'h0000_0008; wdata = 32'hAAAA_5555;
        @(negedge clk);
        chk("abort_stall_idle", {31'd0, stall2}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_stall_wait", {31'd0, stall2}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_stall_async", {31'd0, stall2}, 32'd0);
        chk("abort_data_async",  data2, 32'd0);
        chk("abort_ready_async", {31'd0, ready2}, 32'd0);
        @(posedge clk); #1;
        chk("abort_mem2_kept", dut.mem_r[2], 32'h2222_2222);
        chk("abort_ready_edge", {31'd0, ready2}, 32'd0);
        rst_n = 1'b1;
        do_access(1'b0, 1'b1, 32'h0000_0008, 32'hAAAA_5555, 32'h0, 1'b0);
        do_access(1'b1, 1'b0, 32'h0000_0008, 32'h0, 32'hAAAA_5555, 1'b0);
        idle();
        repeat (2) @(posedge clk);
        #1;

        // LATENCY=1 instance: four back-to-back loads.
        dut1.mem_r[0] = 32'hA0A0_0000;
        dut1.mem_r[1] = 32'hA1A1_1111;
        dut1.mem_r[2] = 32'hA2A2_2222;
        dut1.mem_r[3] = 32'hA3A3_3333;
        sel = 1'b1; lat = 1;
        do_access(1'b1, 1'b0, 32'h0000_0000, 32'h0, 32'hA0A0_0000, 1'b0);
        prev_ready = last_ready_cyc;
        do_access(1'b1, 1'b0, 32'h0000_0004, 32'h0, 32'hA1A1_1111, 1'b0);
        chk("ready_spacing_l1_a", last_ready_cyc - prev_ready, 32'd2);
        prev_ready = last_ready_cyc;
        do_access(1'b1, 1'b0, 32'h0000_0008, 32'h0, 32'hA2A2_2222, 1'b0);
        chk("ready_spacing_l1_b", last_ready_cyc - prev_ready, 32'd2);
        prev_ready = last_ready_cyc;
        do_access(1'b1, 1'b0, 32'h0000_000C, 32'h0, 32'hA3A3_3333, 1'b0);
        chk("ready_spacing_l1_c", last_ready_cyc - prev_ready, 32'd2);
        idle();
        @(posedge clk); #1;
        @(negedge clk);
        chk("l1_idle_ready", {31'd0, ready1}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
